run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller that sequences one program execution on the single-cycle core inside `top_level`. It converts the external `start`/`done` handshake into core control: it holds the PC at 0 while idle, enables the core on the falling edge of `start`, and detects program completion from the fetch PC or a decoded halt. It also counts execution cycles and enforces a watchdog so a runaway program still returns `done`. The block sits between the `top_level` ports and the fetch unit/PC register.

## Interface
- `PROG_LENGTH`, default 119: last PC index of the loaded program; the instruction at this index is the final one.
- `PC_W`, default 10: width of the PC.
- `MAX_CYCLES`, default 50000: watchdog limit in RUN cycles; must be at most 65535.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request from the bench; a falling edge initiates the program.
- `pc`  in  PC_W  current fetch PC, from the PC register.
- `halt_instr`  in  1  decoder flags a halt opcode at the current `pc`.
- `run_en`  out  1  core enable; when 0, the PC, register file and memory writes hold.
- `pc_rst`  out  1  forces the PC register to 0 on the next edge.
- `done`  out  1  acknowledge that the program has finished.
- `timeout`  out  1  `done` was caused by the watchdog.
- `overrun`  out  1  `pc` exceeded `PROG_LENGTH` while running.
- `cycles`  out  16  number of RUN cycles in the last or current run.

## Operation
- **States:** IDLE, ARMED, RUN, DONE.
- **Reset** (`reset`=0 sampled at an edge), from any state:
  - state goes to IDLE.
  - `run_en`=0, `pc_rst`=1, `done`=0, `timeout`=0, `overrun`=0, `cycles`=0.
- **IDLE:**
  - `pc_rst`=1, `run_en`=0.
  - `start`=1 sampled → ARMED.
  - `start`=0 stays in IDLE; a low level alone never starts a run.
- **ARMED:**
  - `pc_rst`=1, `run_en`=0.
  - `start`=0 sampled (the falling edge) → RUN; at the same edge clear `cycles`, `timeout` and `overrun`.
- **RUN:**
  - `run_en`=1, `pc_rst`=0.
  - `cycles` increments by 1 every RUN cycle.
  - `start` is ignored.
  - Finish condition (any of the following) → DONE:
    - `pc`==`PROG_LENGTH`. That instruction executes this cycle because `run_en` is still 1.
    - `halt_instr`=1. The halt instruction commits no state beyond the PC.
    - `pc` > `PROG_LENGTH`. Also set `overrun`=1.
    - `cycles`==`MAX_CYCLES`-1 at this edge. Also set `timeout`=1.
  - Simultaneous conditions: go to DONE once and set every applicable flag.
- **DONE:**
  - `done`=1, `run_en`=0, `pc_rst`=0; the PC holds its final value.
  - `cycles`, `timeout` and `overrun` hold.
  - `start`=1 sampled → ARMED, which clears `done` and asserts `pc_rst`.
- **Arithmetic:**
  - `cycles` is unsigned 16-bit and cannot wrap, because the watchdog trips first.
  - `pc` comparisons are unsigned at `PC_W` bits; `PROG_LENGTH` is truncated to `PC_W`.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- **Start latency:**
  - `start` is sampled 0 at edge N in ARMED.
  - `run_en`=1 during cycle N..N+1, so the instruction at PC 0 executes in the first RUN cycle.
- **Done latency:**
  - The last instruction executes in cycle K.
  - `done` rises after edge K+1 and stays high until `start`=1 is sampled.
- **Cycle count:** for a straight-line program of L+1 instructions (PC 0..L, L=`PROG_LENGTH`), `cycles`=L+1 in DONE.
- **Reset mid-RUN:** the run aborts at that edge; the next run still requires the IDLE→ARMED→RUN sequence.
- `start` held high indefinitely: the block remains in ARMED and the PC remains 0.
- **Glitches on `start`:** `start` is sampled only at clock edges. A pulse shorter than one clock that falls and rises between edges is not seen.

## Test plan
- **Normal run:**
  - Stimulus: `PROG_LENGTH`=5; `pc` increments while `run_en`=1; reset released with `start`=1, then `start` drops.
  - Required: `run_en` high for exactly 6 cycles; `done`=1 with `cycles`=6 and `timeout`=0, `overrun`=0.
- **Early halt:**
  - Stimulus: `halt_instr`=1 when `pc`=3 (`PROG_LENGTH`=119).
  - Required: DONE after 4 RUN cycles; `cycles`=4, `overrun`=0.
- **Watchdog:**
  - Stimulus: `MAX_CYCLES`=20; `pc` stuck at 2.
  - Required: `done`=1 and `timeout`=1 after exactly 20 RUN cycles; `cycles`=20.
- **Overrun:**
  - Stimulus: `pc` jumps from 4 to 200 (`PROG_LENGTH`=119).
  - Required: DONE on the next edge with `overrun`=1, `cycles`=2.
- **Reset mid-run:**
  - Stimulus: `reset`=0 for one edge at RUN cycle 7.
  - Required: `run_en`=0, `pc_rst`=1, `done`=0, `cycles`=0. Then `start` 1→0 re-runs from PC 0 with correct completion.
- **Restart after done:**
  - Stimulus: in DONE, `start`=1 for 2 cycles, then 0.
  - Required: `done` falls one edge after `start` is sampled 1; a second full run completes with the same `cycles`.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: turns the start/done handshake into core enable and PC reset,
// detects program completion, counts RUN cycles and trips a watchdog on runaway programs.
module run_ctrl #(
    parameter int PROG_LENGTH = 119,
    parameter int PC_W        = 10,
    parameter int MAX_CYCLES  = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] pc,
    input  logic            halt_instr,
    output logic            run_en,
    output logic            pc_rst,
    output logic            done,
    output logic            timeout,
    output logic            overrun,
    output logic [15:0]     cycles
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LENGTH);
    localparam logic [15:0]     WD_LAST = 16'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cycles_q, cycles_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;

    logic pc_last, pc_over, wd_trip;

    assign pc_last = (pc == LAST_PC);
    assign pc_over = (pc > LAST_PC);
    assign wd_trip = (cycles_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARMED;
            end
            S_ARMED: begin
                // The run begins on the falling edge of start, seen as a low sample here.
                if (!start) begin
                    state_d   = S_RUN;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            S_RUN: begin
                cycles_d = cycles_q + 16'd1;
                if (pc_over) overrun_d = 1'b1;
                if (wd_trip) timeout_d = 1'b1;
                if (pc_last || pc_over || halt_instr || wd_trip) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decode the state register only, so no input reaches them combinationally.
    assign run_en  = (state_q == S_RUN);
    assign pc_rst  = (state_q == S_IDLE) || (state_q == S_ARMED);
    assign done    = (state_q == S_DONE);
    assign timeout = timeout_q;
    assign overrun = overrun_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized PC/halt traces
// compared against a per-cycle finish-rule model of the run.
module tb_run_ctrl;

    localparam int L    = 5;
    localparam int PCW  = 10;
    localparam int MAXC = 20;
    localparam int SEQN = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [PCW-1:0] pc;
    logic        halt_instr;
    logic        run_en, pc_rst, done, timeout, overrun;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_errors = 0;

    int pc_seq   [SEQN];
    bit halt_seq [SEQN];

    run_ctrl #(.PROG_LENGTH(L), .PC_W(PCW), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .halt_instr(halt_instr),
        .run_en(run_en), .pc_rst(pc_rst), .done(done), .timeout(timeout),
        .overrun(overrun), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result of a run: the first RUN cycle meeting any finish rule ends it.
    function automatic void model(output int ec, output bit et, output bit eo);
        ec = 0; et = 1'b0; eo = 1'b0;
        for (int k = 0; k < SEQN; k++) begin
            if (pc_seq[k] == L || halt_seq[k] || pc_seq[k] > L || k == MAXC - 1) begin
                ec = k + 1;
                eo = (pc_seq[k] > L);
                et = (k == MAXC - 1);
                break;
            end
        end
    endfunction

    task automatic fill_straight();
        for (int i = 0; i < SEQN; i++) begin
            pc_seq[i] = i; halt_seq[i] = 1'b0;
        end
    endtask

    // Optionally arms, drops start, then plays pc_seq/halt_seq while run_en is high.
    task automatic launch(input bit do_arm, output int run_cnt, output bit finished);
        int k;
        k = 0; finished = 1'b0;
        if (do_arm) begin
            start = 1'b1; tick();
        end
        start = 1'b0; tick();
        for (int c = 0; c < 200; c++) begin
            if (done) begin finished = 1'b1; break; end
            if (run_en) begin
                pc = PCW'(pc_seq[k % SEQN]); halt_instr = halt_seq[k % SEQN]; k++;
            end else begin
                halt_instr = 1'b0;
                if (pc_rst) pc = '0;
            end
            tick();
        end
        halt_instr = 1'b0;
        run_cnt = k;
        $display("run: run_en cycles=%0d done=%0b cycles=%0d timeout=%0b overrun=%0b",
                 run_cnt, done, cycles, timeout, overrun);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pc = '0; halt_instr = 1'b0;
        tick(); tick();
        n_checks++; if (run_en !== 1'b0) begin n_errors++; $display("FAIL reset_run_en: got %b expected 0", run_en); end
        n_checks++; if (pc_rst !== 1'b1) begin n_errors++; $display("FAIL reset_pc_rst: got %b expected 1", pc_rst); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if ({timeout, overrun} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b expected 00", {timeout, overrun}); end
        n_checks++; if (cycles !== 16'd0) begin n_errors++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
        reset = 1'b1;
        repeat (4) tick();
        n_checks++; if (run_en !== 1'b0 || pc_rst !== 1'b1) begin n_errors++; $display("FAIL idle_low_start: got run_en=%b pc_rst=%b expected 0/1", run_en, pc_rst); end
        $display("reset: run_en=%b pc_rst=%b done=%b cycles=%0d", run_en, pc_rst, done, cycles);
    endtask

    task automatic test_start_held();
        start = 1'b1;
        repeat (10) tick();
        n_checks++; if (run_en !== 1'b0 || pc_rst !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL start_held: got run_en=%b pc_rst=%b done=%b expected 0/1/0", run_en, pc_rst, done); end
        $display("start_held: run_en=%b pc_rst=%b", run_en, pc_rst);
    endtask

    task automatic test_normal();
        int rc; bit fin; logic [15:0] held;
        fill_straight();
        launch(1'b0, rc, fin);  // already armed by the held start
        n_checks++; if (fin !== 1'b1) begin n_errors++; $display("FAIL normal_done: got %b expected 1", fin); end
        n_checks++; if (rc != L + 1) begin n_errors++; $display("FAIL normal_run_len: got %0d expected %0d", rc, L + 1); end
        n_checks++; if (cycles !== 16'(L + 1)) begin n_errors++; $display("FAIL normal_cycles: got %0d expected %0d", cycles, L + 1); end
        n_checks++; if ({timeout, overrun} !== 2'b00) begin n_errors++; $display("FAIL normal_flags: got %b expected 00", {timeout, overrun}); end
        n_checks++; if (run_en !== 1'b0 || pc_rst !== 1'b0) begin n_errors++; $display("FAIL normal_done_ctrl: got run_en=%b pc_rst=%b expected 0/0", run_en, pc_rst); end
        held = cycles;
        repeat (3) tick();
        n_checks++; if (cycles !== held || done !== 1'b1) begin n_errors++; $display("FAIL done_hold: got cycles=%0d done=%b expected %0d/1", cycles, done, held); end
    endtask

    task automatic test_restart();
        int rc; bit fin;
        start = 1'b1; tick();
        n_checks++; if (done !== 1'b0 || pc_rst !== 1'b1) begin n_errors++; $display("FAIL restart_ack: got done=%b pc_rst=%b expected 0/1", done, pc_rst); end
        tick();
        n_checks++; if (run_en !== 1'b0) begin n_errors++; $display("FAIL restart_armed: got run_en=%b expected 0", run_en); end
        fill_straight();
        launch(1'b0, rc, fin);
        n_checks++; if (fin !== 1'b1 || cycles !== 16'(L + 1)) begin n_errors++; $display("FAIL restart_cycles: got done=%b cycles=%0d expected 1/%0d", fin, cycles, L + 1); end
    endtask

    task automatic test_halt();
        int rc; bit fin;
        fill_straight();
        halt_seq[3] = 1'b1;
        launch(1'b1, rc, fin);
        n_checks++; if (fin !== 1'b1 || cycles !== 16'd4 || rc != 4) begin n_errors++; $display("FAIL halt_cycles: got done=%b cycles=%0d run_len=%0d expected 1/4/4", fin, cycles, rc); end
        n_checks++; if ({timeout, overrun} !== 2'b00) begin n_errors++; $display("FAIL halt_flags: got %b expected 00", {timeout, overrun}); end
    endtask

    task automatic test_watchdog();
        int rc; bit fin;
        for (int i = 0; i < SEQN; i++) begin pc_seq[i] = 2; halt_seq[i] = 1'b0; end
        launch(1'b1, rc, fin);
        n_checks++; if (fin !== 1'b1 || cycles !== 16'(MAXC) || rc != MAXC) begin n_errors++; $display("FAIL watchdog_cycles: got done=%b cycles=%0d run_len=%0d expected 1/%0d/%0d", fin, cycles, rc, MAXC, MAXC); end
        n_checks++; if ({timeout, overrun} !== 2'b10) begin n_errors++; $display("FAIL watchdog_flags: got %b expected 10", {timeout, overrun}); end
    endtask

    task automatic test_overrun();
        int rc; bit fin;
        fill_straight();
        pc_seq[0] = 4; pc_seq[1] = 200;
        launch(1'b1, rc, fin);
        n_checks++; if (fin !== 1'b1 || cycles !== 16'd2) begin n_errors++; $display("FAIL overrun_cycles: got done=%b cycles=%0d expected 1/2", fin, cycles); end
        n_checks++; if ({timeout, overrun} !== 2'b01) begin n_errors++; $display("FAIL overrun_flags: got %b expected 01", {timeout, overrun}); end
    endtask

    task automatic test_simultaneous();
        int rc; bit fin;
        for (int i = 0; i < SEQN; i++) begin pc_seq[i] = 1; halt_seq[i] = 1'b0; end
        pc_seq[MAXC - 1] = 300;
        halt_seq[MAXC - 1] = 1'b1;
        launch(1'b1, rc, fin);
        n_checks++; if (fin !== 1'b1 || cycles !== 16'(MAXC) || {timeout, overrun} !== 2'b11) begin n_errors++; $display("FAIL simultaneous: got done=%b cycles=%0d flags=%b expected 1/%0d/11", fin, cycles, {timeout, overrun}, MAXC); end
    endtask

    task automatic test_reset_mid_run();
        int rc; bit fin;
        start = 1'b1; tick();
        start = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin pc = PCW'(1); tick(); end
        n_checks++; if (run_en !== 1'b1 || cycles !== 16'd6) begin n_errors++; $display("FAIL midrun_pre: got run_en=%b cycles=%0d expected 1/6", run_en, cycles); end
        reset = 1'b0; tick();
        n_checks++; if (run_en !== 1'b0 || pc_rst !== 1'b1 || done !== 1'b0 || cycles !== 16'd0) begin n_errors++; $display("FAIL midrun_reset: got run_en=%b pc_rst=%b done=%b cycles=%0d expected 0/1/0/0", run_en, pc_rst, done, cycles); end
        reset = 1'b1; pc = '0;
        repeat (3) tick();
        n_checks++; if (run_en !== 1'b0) begin n_errors++; $display("FAIL midrun_no_autostart: got run_en=%b expected 0", run_en); end
        fill_straight();
        launch(1'b1, rc, fin);
        n_checks++; if (fin !== 1'b1 || cycles !== 16'(L + 1) || rc != L + 1) begin n_errors++; $display("FAIL midrun_rerun: got done=%b cycles=%0d run_len=%0d expected 1/%0d/%0d", fin, cycles, rc, L + 1, L + 1); end
    endtask

    task automatic test_random();
        int rc, ec; bit fin, et, eo;
        int mode, jmp, hpos;
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 3));
            jmp  = int'($urandom_range(0, 25));
            hpos = int'($urandom_range(0, 40));
            for (int i = 0; i < SEQN; i++) begin
                case (mode)
                    0: pc_seq[i] = i;
                    1: pc_seq[i] = int'($urandom_range(0, 4));
                    2: pc_seq[i] = (i == jmp) ? int'($urandom_range(0, 1023)) : (i % 5);
                    default: pc_seq[i] = int'($urandom_range(0, 7));
                endcase
                halt_seq[i] = (i == hpos);
            end
            model(ec, et, eo);
            launch(1'b1, rc, fin);
            n_checks++; if (fin !== 1'b1 || rc != ec || cycles !== 16'(ec)) begin n_errors++; $display("FAIL random_cycles[%0d]: got done=%b run_len=%0d cycles=%0d expected 1/%0d/%0d", t, fin, rc, cycles, ec, ec); end
            n_checks++; if ({timeout, overrun} !== {et, eo}) begin n_errors++; $display("FAIL random_flags[%0d]: got %b expected %b", t, {timeout, overrun}, {et, eo}); end
        end
    endtask

    initial begin
        test_reset();
        test_start_held();
        test_normal();
        test_restart();
        test_halt();
        test_watchdog();
        test_overrun();
        test_simultaneous();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
